// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between the fetch queue, the instruction memory and the datapath.
// The master modport is the fetch unit; the slave modport is its environment.
interface inst_fetch_queue_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_pc,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_pc,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        input  fetch_fault
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetch with in-order response queue and redirect flush.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect sets sticky fetch_fault and halts issue.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                clk,
    input logic                rst,
    inst_fetch_queue_if.master bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   pf_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, pf_rd, pf_wr;
    logic [CW-1:0] count, outstanding, discard, out_after;
    logic [31:0]   target_pc;
    logic          fault, credit, accept, rsp_keep, rsp_drop, pop;

    // Credit covers both buffered and in-flight fetches so a response always has a slot.
    assign credit    = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_W;
    assign bus.imem_req_valid = rst & credit & ~bus.redirect & ~fault;
    assign bus.imem_req_addr  = fetch_pc;
    assign accept    = bus.imem_req_valid & bus.imem_req_ready;
    assign rsp_drop  = bus.imem_rsp_valid & (discard != '0);
    assign rsp_keep  = bus.imem_rsp_valid & (discard == '0);
    assign bus.inst_valid = (count != '0);
    assign pop       = bus.inst_valid & bus.inst_ready;
    assign bus.inst       = q_inst[rd_ptr];
    assign bus.inst_pc    = q_pc[rd_ptr];
    assign out_after = outstanding - CW'(bus.imem_rsp_valid);
    assign bus.fetch_fault = fault;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target_pc = bus.redirect_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fault <= 1'b0;
        else if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00))
            fault <= 1'b1;
    end
`else
    assign target_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    assign fault     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pf_rd       <= '0;
            pf_wr       <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
                pf_mem[i] <= '0;
            end
        end else if (bus.redirect) begin
            // Everything still in flight becomes stale and is dropped on return.
            fetch_pc    <= target_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pf_rd       <= '0;
            pf_wr       <= '0;
            count       <= '0;
            outstanding <= out_after;
            discard     <= out_after;
        end else begin
            if (accept) begin
                pf_mem[pf_wr] <= fetch_pc;
                pf_wr         <= pf_wr + AW'(1);
                fetch_pc      <= fetch_pc + 32'd4;
            end
            if (rsp_keep) begin
                q_pc[wr_ptr]   <= pf_mem[pf_rd];
                q_inst[wr_ptr] <= bus.imem_rsp_data;
                wr_ptr         <= wr_ptr + AW'(1);
                pf_rd          <= pf_rd + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (rsp_drop)
                discard <= discard - CW'(1);
            count       <= count + CW'(rsp_keep) - CW'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(bus.imem_rsp_valid);
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: memory model with configurable latency and a PC scoreboard.
module tb_inst_fetch_queue;
    typedef struct { logic [31:0] data; int due; } rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    inst_fetch_queue_if b();

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] key = 32'h0;
    bit          rdy_rand = 1'b0;
    bit          ir_rand  = 1'b0;
    rsp_t        pend[$];
    exp_t        exq[$];
    logic [31:0] model_pc = 32'h0;
    bit          model_fault = 1'b0;
    bit          hold_prev = 1'b0;
    logic [31:0] hold_addr = 32'h0;
    int          n_acc = 0;
    int          n_pop = 0;
    bit          s_pop, s_req_valid, s_inst_valid, s_fault;
    logic [31:0] s_addr, s_pop_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        b.redirect = 1'b0;
        b.imem_rsp_valid = 1'b0;
        b.imem_rsp_data = 32'h0;
        pend.delete();
        exq.delete();
        model_pc = 32'h0;
        model_fault = 1'b0;
        hold_prev = 1'b0;
        @(negedge clk);
        chk("rst_req_valid",  32'(b.imem_req_valid), 32'd0);
        chk("rst_req_addr",   b.imem_req_addr,       32'h0);
        chk("rst_inst_valid", 32'(b.inst_valid),     32'd0);
        chk("rst_inst",       b.inst,                32'h0);
        chk("rst_inst_pc",    b.inst_pc,             32'h0);
        chk("rst_fault",      32'(b.fetch_fault),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic cycle();
        logic acc, pop;
        exp_t e;
        b.imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ir_rand) b.inst_ready = 1'($urandom_range(0, 1));
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            b.imem_rsp_valid = 1'b1;
            b.imem_rsp_data  = pend[0].data;
        end else begin
            b.imem_rsp_valid = 1'b0;
            b.imem_rsp_data  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        acc = b.imem_req_valid & b.imem_req_ready;
        pop = b.inst_valid & b.inst_ready;
        s_pop = pop; s_req_valid = b.imem_req_valid; s_inst_valid = b.inst_valid;
        s_fault = b.fetch_fault; s_addr = b.imem_req_addr; s_pop_pc = b.inst_pc;
        if (hold_prev && !b.redirect) begin
            chk("hold_valid", 32'(b.imem_req_valid), 32'd1);
            chk("hold_addr",  b.imem_req_addr,       hold_addr);
        end
        if (b.redirect)  chk("redirect_no_req", 32'(b.imem_req_valid), 32'd0);
        chk("fault_flag", 32'(b.fetch_fault), 32'(model_fault));
        if (model_fault) chk("halted_no_req", 32'(b.imem_req_valid), 32'd0);
        if (pop) begin
            n_pop++;
            n_checks++;
            assert (exq.size() > 0) else begin
                n_errors++;
                $error("FAIL pop_unexpected: observed pc %h expected no instruction", b.inst_pc);
            end
            if (exq.size() > 0) begin
                e = exq.pop_front();
                chk("pop_pc",   b.inst_pc, e.pc);
                chk("pop_inst", b.inst,    e.ins);
            end
        end
        if (acc) begin
            chk("accept_addr", b.imem_req_addr, model_pc);
            pend.push_back('{data: b.imem_req_addr ^ key, due: cyc + lat});
            exq.push_back('{pc: model_pc, ins: model_pc ^ key});
            model_pc += 32'd4;
            n_acc++;
        end
        if (b.imem_rsp_valid) void'(pend.pop_front());
        hold_prev = b.imem_req_valid & ~b.imem_req_ready;
        hold_addr = b.imem_req_addr;
        if (b.redirect) begin
            exq.delete();
            hold_prev = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            if (b.redirect_pc[1:0] != 2'b00) model_fault = 1'b1;
            model_pc = b.redirect_pc;
`else
            model_pc = b.redirect_pc & 32'hFFFF_FFFC;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] expv);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!s_pop && k < 30);
        chk(tag, s_pop ? s_pop_pc : 32'hFFFF_FFFF, expv);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        b.redirect = 1'b1;
        b.redirect_pc = pc;
        cycle();
        b.redirect = 1'b0;
    endtask

    initial begin
        b.imem_req_ready = 1'b1;
        b.imem_rsp_valid = 1'b0;
        b.imem_rsp_data  = 32'h0;
        b.redirect       = 1'b0;
        b.redirect_pc    = 32'h0;
        b.inst_ready     = 1'b0;
        #2;
        do_reset();

        // Streaming at one instruction per cycle, data equals address.
        lat = 1; key = 32'h0; b.inst_ready = 1'b1;
        run(2);
        n_pop = 0;
        run(16);
        chk("t1_throughput", 32'(n_pop), 32'd16);

        // Backpressure: credit stops issue after DEPTH fetches, then resumes at 0x10.
        do_reset();
        key = 32'h5A5A_0000; b.inst_ready = 1'b0; n_acc = 0;
        run(10);
        chk("t2_accepts",    32'(n_acc),        32'd4);
        chk("t2_req_idle",   32'(s_req_valid),  32'd0);
        chk("t2_inst_valid", 32'(s_inst_valid), 32'd1);
        b.inst_ready = 1'b1; n_pop = 0;
        for (int k = 0; k < 20 && n_pop < 5; k++) cycle();
        chk("t2_resume_pc", s_pop_pc, 32'h10);

        // Three outstanding with latency 3, then redirect.
        do_reset();
        lat = 3; key = 32'h0000_FFFF; b.inst_ready = 1'b1;
        run(3);
        do_redirect(32'h100);
        cycle();
        chk("t3_req_valid",  32'(s_req_valid),  32'd1);
        chk("t3_req_addr",   s_addr,            32'h100);
        chk("t3_inst_valid", 32'(s_inst_valid), 32'd0);
        wait_pop("t3_first_pc",  32'h100);
        wait_pop("t3_second_pc", 32'h104);

        // Redirect coinciding with a response and a pop.
        do_reset();
        lat = 1; key = 32'h1357_0000; b.inst_ready = 1'b1;
        run(6);
        do_redirect(32'h200);
        chk("t4_head_popped", 32'(s_pop), 32'd1);
        cycle();
        chk("t4_inst_valid", 32'(s_inst_valid), 32'd0);
        chk("t4_req_valid",  32'(s_req_valid),  32'd1);
        chk("t4_req_addr",   s_addr,            32'h200);
        wait_pop("t4_target_pc", 32'h200);
        run(8);

        // Random memory and datapath backpressure.
        do_reset();
        lat = 2; key = 32'hCAFE_0000; rdy_rand = 1'b1; ir_rand = 1'b1; n_acc = 0;
        run(300);
        rdy_rand = 1'b0; ir_rand = 1'b0; b.inst_ready = 1'b1;
        run(10);
        chk("t5_progress", 32'(n_acc > 50), 32'd1);

        // Misaligned redirect.
        do_reset();
        lat = 1; key = 32'h0; b.inst_ready = 1'b1;
        run(5);
        do_redirect(32'h102);
        cycle();
`ifdef FETCH_MISALIGN_CHK_EN
        chk("t6_fault",     32'(s_fault),     32'd1);
        chk("t6_req_valid", 32'(s_req_valid), 32'd0);
        run(10);
`else
        chk("t6_fault",     32'(s_fault),     32'd0);
        chk("t6_req_valid", 32'(s_req_valid), 32'd1);
        chk("t6_req_addr",  s_addr,           32'h100);
        wait_pop("t6_target_pc", 32'h100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected finish before time 100000");
        $fatal(1, "watchdog expired");
    end
endmodule
